// File: rtl/ed_evt_arb.sv
// rtl/ed_evt_arb.sv - Round-robin edge-event scheduler with per-channel pending slots
// Detected edges wait in a one-deep slot per channel and drain through a registered valid/ready output.
module ed_evt_arb #(
  parameter int   N_CH           = 4,
  parameter int   IDX_W          = 2,
  parameter logic IN_RESET_VALUE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  in,
  input  logic [N_CH-1:0]  ris_en,
  input  logic [N_CH-1:0]  fal_en,
  input  logic             clr_ovf,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_ch,
  output logic             evt_ris,
  output logic [N_CH-1:0]  ovf
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [N_CH-1:0]  prev;
  logic [N_CH-1:0]  pend, pend_nxt;
  logic [N_CH-1:0]  pend_ris, pend_ris_nxt;
  logic [N_CH-1:0]  rise, fall, edge_det, drop, ovf_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_nxt;
  logic [IDX_W-1:0] gnt_idx, evt_ch_nxt;
  logic [IDX_W:0]   cand_sum;
  logic             gnt_found, load, evt_ris_nxt;

  assign rise      = in & ~prev & ris_en;
  assign fall      = ~in & prev & fal_en;
  assign edge_det  = rise | fall;
  assign load      = (state == EMPTY) || evt_ready;
  assign evt_valid = (state == FULL);

  // Scan offsets from farthest to nearest so the nearest pending channel after rr_ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(N_CH)) begin
        cand_sum = cand_sum - (IDX_W+1)'(N_CH);
      end
      if (pend[cand_sum[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_sum[IDX_W-1:0];
      end
    end
  end

  // A slot granted this cycle is free again, so a same-cycle edge refills it without overflow.
  always_comb begin
    pend_nxt     = pend;
    pend_ris_nxt = pend_ris;
    drop         = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (load && gnt_found && (gnt_idx == IDX_W'(i))) begin
        pend_nxt[i] = 1'b0;
      end
      if (edge_det[i]) begin
        if (!pend_nxt[i]) begin
          pend_nxt[i]     = 1'b1;
          pend_ris_nxt[i] = rise[i];
        end else begin
          drop[i] = 1'b1;
        end
      end
    end
    ovf_nxt = (clr_ovf ? '0 : ovf) | drop;
  end

  always_comb begin
    state_nxt   = state;
    evt_ch_nxt  = evt_ch;
    evt_ris_nxt = evt_ris;
    rr_nxt      = rr_ptr;
    if (load) begin
      if (gnt_found) begin
        state_nxt   = FULL;
        evt_ch_nxt  = gnt_idx;
        evt_ris_nxt = pend_ris[gnt_idx];
        rr_nxt      = gnt_idx;
      end else begin
        state_nxt = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      prev     <= {N_CH{IN_RESET_VALUE}};
      pend     <= '0;
      pend_ris <= '0;
      ovf      <= '0;
      evt_ch   <= '0;
      evt_ris  <= 1'b0;
      rr_ptr   <= IDX_W'(N_CH - 1);
    end else begin
      state    <= state_nxt;
      prev     <= in;
      pend     <= pend_nxt;
      pend_ris <= pend_ris_nxt;
      ovf      <= ovf_nxt;
      evt_ch   <= evt_ch_nxt;
      evt_ris  <= evt_ris_nxt;
      rr_ptr   <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_ed_evt_arb.sv
// tb/tb_ed_evt_arb.sv - Self-checking bench for ed_evt_arb
// Directed scenarios with constant expectations plus a randomized run against a slot/queue model.
module tb_ed_evt_arb;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] in = '0;
  logic [N-1:0] ris_en = '0;
  logic [N-1:0] fal_en = '0;
  logic         clr_ovf = 1'b0;
  logic         evt_valid;
  logic         evt_ready = 1'b0;
  logic [1:0]   evt_ch;
  logic         evt_ris;
  logic [N-1:0] ovf;

  int checks = 0;
  int failures = 0;

  // model state: slot = -1 empty, 1 rising, 0 falling
  int       m_slot[N];
  bit       m_valid;
  int       m_ch;
  bit       m_ris;
  int       m_rr;
  logic [N-1:0] m_prev;
  logic [N-1:0] m_ovf;

  ed_evt_arb #(.N_CH(N), .IDX_W(2), .IN_RESET_VALUE(1'b0)) dut (
    .clk(clk), .reset(rst), .in(in), .ris_en(ris_en), .fal_en(fal_en),
    .clr_ovf(clr_ovf), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_ris(evt_ris), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_slot[i] = -1;
    m_valid = 1'b0;
    m_ch    = 0;
    m_ris   = 1'b0;
    m_rr    = N - 1;
    m_prev  = '0;
    m_ovf   = '0;
  endtask

  task automatic model_step();
    int g;
    int c;
    int e;
    int nslot[N];
    bit acc;
    logic [N-1:0] dropped;
    if (rst) begin
      model_reset();
      return;
    end
    acc = !m_valid || evt_ready;
    g = -1;
    if (acc) begin
      for (int off = 1; off <= N; off++) begin
        c = (m_rr + off) % N;
        if (g < 0 && m_slot[c] >= 0) g = c;
      end
    end
    dropped = '0;
    for (int i = 0; i < N; i++) begin
      nslot[i] = (g == i) ? -1 : m_slot[i];
      e = -1;
      if (in[i] && !m_prev[i] && ris_en[i]) e = 1;
      if (!in[i] && m_prev[i] && fal_en[i]) e = 0;
      if (e >= 0) begin
        if (nslot[i] < 0) nslot[i] = e;
        else dropped[i] = 1'b1;
      end
    end
    if (acc) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_ch    = g;
        m_ris   = (m_slot[g] == 1);
        m_rr    = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) m_slot[i] = nslot[i];
    m_ovf  = (clr_ovf ? '0 : m_ovf) | dropped;
    m_prev = in;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    checks++;
    if (evt_valid !== 1'b0 || evt_ch !== 2'd0 || evt_ris !== 1'b0 || ovf !== 4'b0000) begin
      failures++;
      $display("FAIL reset_hold got v=%b ch=%0d r=%b ovf=%b exp 0/0/0/0000", evt_valid, evt_ch, evt_ris, ovf);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (evt_valid !== 1'b0 || ovf !== 4'b0000) begin
      failures++;
      $display("FAIL reset_release got v=%b ovf=%b exp 0/0000", evt_valid, ovf);
    end
  endtask

  task automatic test_single_edge();
    ris_en = 4'b0001;
    fal_en = 4'b0000;
    evt_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    in = 4'b0001;
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_c1_valid got=%b exp=0", evt_valid);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_ris !== 1'b1) begin
      failures++;
      $display("FAIL single_c2_event got v=%b ch=%0d r=%b exp 1/0/1", evt_valid, evt_ch, evt_ris);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_c3_valid got=%b exp=0", evt_valid);
    end
    in = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL single_fall_masked cyc=%0d got=%b exp=0", k, evt_valid);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    ris_en = 4'hF;
    fal_en = 4'hF;
    evt_ready = 1'b0;
    in = 4'hF;
    tick();
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_ris !== 1'b1) begin
      failures++;
      $display("FAIL rr_first got v=%b ch=%0d r=%b exp 1/0/1", evt_valid, evt_ch, evt_ris);
    end
    evt_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 2'(k) || evt_ris !== 1'b1) begin
        failures++;
        $display("FAIL rr_seq got v=%b ch=%0d r=%b exp 1/%0d/1", evt_valid, evt_ch, evt_ris, k);
      end
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL rr_drained got=%b exp=0", evt_valid);
    end
    ris_en = '0;
    fal_en = '0;
    in = '0;
    tick();
  endtask

  task automatic test_overflow();
    ris_en = 4'b0100;
    fal_en = 4'b0100;
    evt_ready = 1'b0;
    in = 4'b0100;
    tick();
    in = 4'b0000;
    tick();
    in = 4'b0100;
    tick();
    checks++;
    if (ovf !== 4'b0100) begin
      failures++;
      $display("FAIL ovf_set got=%b exp=0100", ovf);
    end
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_ris !== 1'b1) begin
      failures++;
      $display("FAIL ovf_first_rise got v=%b ch=%0d r=%b exp 1/2/1", evt_valid, evt_ch, evt_ris);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 4'b0000) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0000", ovf);
    end
    evt_ready = 1'b1;
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_ris !== 1'b0) begin
      failures++;
      $display("FAIL ovf_kept_fall got v=%b ch=%0d r=%b exp 1/2/0", evt_valid, evt_ch, evt_ris);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drained got=%b exp=0", evt_valid);
    end
    ris_en = '0;
    fal_en = '0;
    in = '0;
    tick();
  endtask

  task automatic test_collision();
    ris_en = 4'b0011;
    fal_en = 4'b0010;
    evt_ready = 1'b0;
    in = 4'b0011;
    tick();
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_ris !== 1'b1) begin
      failures++;
      $display("FAIL coll_setup got v=%b ch=%0d r=%b exp 1/0/1", evt_valid, evt_ch, evt_ris);
    end
    evt_ready = 1'b1;
    in = 4'b0001;
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_ris !== 1'b1 || ovf[1] !== 1'b0) begin
      failures++;
      $display("FAIL coll_grant got v=%b ch=%0d r=%b ovf=%b exp 1/1/1/xx0x", evt_valid, evt_ch, evt_ris, ovf);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_ris !== 1'b0 || ovf !== 4'b0000) begin
      failures++;
      $display("FAIL coll_fall got v=%b ch=%0d r=%b ovf=%b exp 1/1/0/0000", evt_valid, evt_ch, evt_ris, ovf);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL coll_drained got=%b exp=0", evt_valid);
    end
    ris_en = '0;
    fal_en = '0;
    in = '0;
    evt_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int bad;
    ris_en = 4'hF;
    fal_en = 4'hF;
    evt_ready = 1'b0;
    in = 4'b0001;
    tick();
    tick();
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 3)  in[1] = 1'b1;
      if (k == 5)  in[2] = 1'b1;
      if (k == 8)  in[2] = 1'b0;
      if (k == 10) in[0] = 1'b0;
      tick();
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_ris !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%b ch=%0d r=%b exp 1/0/1", k, evt_valid, evt_ch, evt_ris);
      end
    end
    checks++;
    if (ovf !== 4'b0100) begin
      failures++;
      $display("FAIL bp_ovf got=%b exp=0100", ovf);
    end
    evt_ready = 1'b1;
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1 || evt_ris !== 1'b1) begin
      failures++;
      $display("FAIL bp_ev1 got v=%b ch=%0d r=%b exp 1/1/1", evt_valid, evt_ch, evt_ris);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd2 || evt_ris !== 1'b1) begin
      failures++;
      $display("FAIL bp_ev2 got v=%b ch=%0d r=%b exp 1/2/1", evt_valid, evt_ch, evt_ris);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_ris !== 1'b0) begin
      failures++;
      $display("FAIL bp_ev3 got v=%b ch=%0d r=%b exp 1/0/0", evt_valid, evt_ch, evt_ris);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drained got=%b exp=0", evt_valid);
    end
    clr_ovf = 1'b1;
    ris_en = '0;
    fal_en = '0;
    in = '0;
    tick();
    clr_ovf = 1'b0;
    evt_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    ris_en = 4'hF;
    fal_en = 4'hF;
    evt_ready = 1'b0;
    in = 4'b1011;
    tick();
    tick();
    in = 4'b0011;
    tick();
    checks++;
    if (evt_valid !== 1'b1 || ovf !== 4'b1000) begin
      failures++;
      $display("FAIL arst_setup got v=%b ovf=%b exp 1/1000", evt_valid, ovf);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (evt_valid !== 1'b0 || ovf !== 4'b0000 || evt_ch !== 2'd0 || evt_ris !== 1'b0) begin
      failures++;
      $display("FAIL arst_immediate got v=%b ch=%0d r=%b ovf=%b exp 0/0/0/0000", evt_valid, evt_ch, evt_ris, ovf);
    end
    in = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL arst_pend_cleared cyc=%0d got=%b exp=0", k, evt_valid);
      end
    end
    in = 4'b1001;
    tick();
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd0 || evt_ris !== 1'b1) begin
      failures++;
      $display("FAIL arst_first_ch0 got v=%b ch=%0d r=%b exp 1/0/1", evt_valid, evt_ch, evt_ris);
    end
    evt_ready = 1'b1;
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd3 || evt_ris !== 1'b1) begin
      failures++;
      $display("FAIL arst_next_ch3 got v=%b ch=%0d r=%b exp 1/3/1", evt_valid, evt_ch, evt_ris);
    end
    ris_en = '0;
    fal_en = '0;
    in = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    ris_en = 4'($urandom);
    fal_en = 4'($urandom);
    for (int k = 0; k < 600; k++) begin
      in = 4'($urandom);
      evt_ready = ($urandom_range(0, 3) != 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) begin
        ris_en = 4'($urandom);
        fal_en = 4'($urandom);
      end
      tick();
      checks++;
      if (evt_valid !== m_valid || ovf !== m_ovf) begin
        failures++;
        $display("FAIL rand_state cyc=%0d got v=%b ovf=%b exp v=%b ovf=%b", k, evt_valid, ovf, m_valid, m_ovf);
      end
      if (m_valid) begin
        checks++;
        if (int'(evt_ch) !== m_ch || evt_ris !== m_ris) begin
          failures++;
          $display("FAIL rand_event cyc=%0d got ch=%0d r=%b exp ch=%0d r=%b", k, evt_ch, evt_ris, m_ch, m_ris);
        end
      end
    end
    clr_ovf = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_edge();
    test_round_robin();
    test_overflow();
    test_collision();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
